// File: rtl/secuenciador_pasos_pkg.sv
// Shared types and constants for the step/dir sequencer that time-shares one
// stepper driver between the theta and phi axes.
package secuenciador_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DIR_SETUP = 2'd1,
      PULSE_HI  = 2'd2,
      PULSE_LO  = 2'd3
   } state_t;

   localparam logic AXIS_THETA = 1'b0;
   localparam logic AXIS_PHI   = 1'b1;
   localparam logic DIR_POS    = 1'b1;
   localparam logic DIR_NEG    = 1'b0;

   // Largest of the three timing parameters, used to size the shared timer.
   function automatic int max_cyc(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/secuenciador_pasos_if.sv
// Request/driver bundle of the step sequencer. The motion controller side
// (master) raises per-axis move requests; the sequencer (slave) drives the
// shared stepper driver pins, status flags and the optional step counts.
interface secuenciador_pasos_if;

   logic        req_theta_pos;
   logic        req_theta_neg;
   logic        req_phi_pos;
   logic        req_phi_neg;
   logic        step_out;
   logic        dir_out;
   logic        axis_sel;
   logic        busy;
   logic        conflict;
   logic [15:0] theta_steps;
   logic [15:0] phi_steps;

   modport master (
      output req_theta_pos, req_theta_neg, req_phi_pos, req_phi_neg,
      input  step_out, dir_out, axis_sel, busy, conflict, theta_steps, phi_steps
   );

   modport slave (
      input  req_theta_pos, req_theta_neg, req_phi_pos, req_phi_neg,
      output step_out, dir_out, axis_sel, busy, conflict, theta_steps, phi_steps
   );

endinterface

// File: rtl/secuenciador_pasos_contador.sv
// contador_espera: loadable down-counter used as the single wait timer of the
// sequencer. Loading N-1 makes done assert after N cycles in the timed state.
module contador_espera #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Load has priority; otherwise count down and park at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // Counter register, cleared by the asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/secuenciador_pasos.sv
// secuenciador_pasos: round-robin arbiter and pulse timer sharing one step/dir
// driver between the theta and phi axes. Direction and axis select are only
// changed on a grant from IDLE and are given DIR_SETUP_CYC cycles to settle
// before step_out rises.
// Optional feature: define STEP_COUNT_EN to keep signed 16-bit step counts per
// axis; without it theta_steps/phi_steps are tied to zero.
module secuenciador_pasos
   import secuenciador_pkg::*;
#(
   parameter int PULSE_HI_CYC  = 50,
   parameter int PULSE_LO_CYC  = 50,
   parameter int DIR_SETUP_CYC = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   secuenciador_pasos_if.slave   bus
);

   localparam int TMR_W = $clog2(max_cyc(PULSE_HI_CYC, PULSE_LO_CYC, DIR_SETUP_CYC) + 1);
   localparam logic [TMR_W-1:0] HI_LOAD    = TMR_W'(PULSE_HI_CYC - 1);
   localparam logic [TMR_W-1:0] LO_LOAD    = TMR_W'(PULSE_LO_CYC - 1);
   localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP_CYC - 1);

   state_t           state_q, state_d;
   logic             axis_sel_q, axis_sel_d;
   logic             dir_q, dir_d;
   logic             last_axis_q, last_axis_d;
   logic             conflict_q, conflict_d;

   logic             theta_valid, phi_valid;
   logic             grant_any;
   logic             grant_axis;
   logic             grant_dir;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_done;

   logic             step_c;
   logic             busy_c;

   contador_espera #(.WIDTH(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Arbitration: an axis is valid with exactly one direction requested; on a
   // tie the axis not served last wins.
   always_comb begin
      theta_valid = bus.req_theta_pos ^ bus.req_theta_neg;
      phi_valid   = bus.req_phi_pos ^ bus.req_phi_neg;
      grant_any   = theta_valid | phi_valid;
      grant_axis  = AXIS_THETA;
      if (theta_valid && phi_valid) begin
         grant_axis = ~last_axis_q;
      end else if (phi_valid) begin
         grant_axis = AXIS_PHI;
      end
      if (grant_axis == AXIS_PHI) begin
         grant_dir = bus.req_phi_pos ? DIR_POS : DIR_NEG;
      end else begin
         grant_dir = bus.req_theta_pos ? DIR_POS : DIR_NEG;
      end
      conflict_d = (bus.req_theta_pos & bus.req_theta_neg) |
                   (bus.req_phi_pos & bus.req_phi_neg);
   end

   // State register plus the registered axis/direction, round-robin pointer and conflict flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         axis_sel_q  <= AXIS_THETA;
         dir_q       <= DIR_NEG;
         last_axis_q <= AXIS_PHI;
         conflict_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         axis_sel_q  <= axis_sel_d;
         dir_q       <= dir_d;
         last_axis_q <= last_axis_d;
         conflict_q  <= conflict_d;
      end
   end

   // Next-state logic; a grant that keeps axis and direction skips the setup wait.
   always_comb begin
      state_d     = state_q;
      axis_sel_d  = axis_sel_q;
      dir_d       = dir_q;
      last_axis_d = last_axis_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               last_axis_d = grant_axis;
               axis_sel_d  = grant_axis;
               dir_d       = grant_dir;
               tmr_load    = 1'b1;
               if ((grant_axis == axis_sel_q) && (grant_dir == dir_q)) begin
                  state_d = PULSE_HI;
                  tmr_val = HI_LOAD;
               end else begin
                  state_d = DIR_SETUP;
                  tmr_val = SETUP_LOAD;
               end
            end
         end
         DIR_SETUP: begin
            if (tmr_done) begin
               state_d  = PULSE_HI;
               tmr_load = 1'b1;
               tmr_val  = HI_LOAD;
            end
         end
         PULSE_HI: begin
            if (tmr_done) begin
               state_d  = PULSE_LO;
               tmr_load = 1'b1;
               tmr_val  = LO_LOAD;
            end
         end
         PULSE_LO: begin
            if (tmr_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from the state register so reset drops step_out at once.
   always_comb begin
      step_c = (state_q == PULSE_HI);
      busy_c = (state_q != IDLE);
   end

   assign bus.step_out = step_c;
   assign bus.busy     = busy_c;
   assign bus.dir_out  = dir_q;
   assign bus.axis_sel = axis_sel_q;
   assign bus.conflict = conflict_q;

`ifdef STEP_COUNT_EN
   logic [15:0] theta_steps_q, theta_steps_d;
   logic [15:0] phi_steps_q, phi_steps_d;
   logic        pulse_end;

   // Count each completed pulse on the granted axis; wraps as 16-bit two's complement.
   always_comb begin
      theta_steps_d = theta_steps_q;
      phi_steps_d   = phi_steps_q;
      pulse_end     = (state_q == PULSE_HI) && tmr_done;
      if (pulse_end) begin
         if (axis_sel_q == AXIS_THETA) begin
            theta_steps_d = (dir_q == DIR_POS) ? theta_steps_q + 16'd1 : theta_steps_q - 16'd1;
         end else begin
            phi_steps_d = (dir_q == DIR_POS) ? phi_steps_q + 16'd1 : phi_steps_q - 16'd1;
         end
      end
   end

   // Step count registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         theta_steps_q <= 16'd0;
         phi_steps_q   <= 16'd0;
      end else begin
         theta_steps_q <= theta_steps_d;
         phi_steps_q   <= phi_steps_d;
      end
   end

   assign bus.theta_steps = theta_steps_q;
   assign bus.phi_steps   = phi_steps_q;
`else
   assign bus.theta_steps = 16'd0;
   assign bus.phi_steps   = 16'd0;
`endif

endmodule
